// File: rtl/gray_ctr_bank_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_ctr_bank_arb_pkg : shared types and Gray/binary conversion helpers      |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package gray_ctr_bank_arb_pkg;

  localparam int CNT_W = 16;
  localparam int MAX_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b = g;
    for (int s = 1; s < MAX_W; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_ctr_bank_arb_incgray.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | IncGray : combinational Gray-code incrementer (modulo 2^WIDTH)               |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module IncGray
  import gray_ctr_bank_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPEED = 2
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_gray
);

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_sum;

  // Gray-to-binary is a suffix XOR from the MSB; SPEED picks a ripple or log-depth scan.
  generate
    if (SPEED == 0) begin : g_serial
      always_comb begin
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = i_gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
          b[i] = b[i+1] ^ i_gray[i];
        end
        w_bin = b;
      end
    end else begin : g_prefix
      always_comb begin
        logic [WIDTH-1:0] b;
        b = i_gray;
        for (int s = 1; s < WIDTH; s = s * 2) begin
          b = b ^ (b >> s);
        end
        w_bin = b;
      end
    end
  endgenerate

  assign w_sum  = w_bin + 1'b1;
  assign o_gray = WIDTH'(bin2gray(word_t'(w_sum)));

endmodule
`default_nettype wire

// File: rtl/gray_ctr_bank_arb_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_rr_arb : round-robin arbiter, one-hot grant, pointer moves past winner  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module gray_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] i_req,
  input  logic [NUM_CH-1:0] i_mask,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_valid
);

  logic [IDX_W-1:0]  r_rr;
  logic [NUM_CH-1:0] w_elig;

  assign w_elig = i_req & ~i_mask;

  // Scan offsets high to low so the smallest offset from r_rr wins last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(r_rr) + i) % NUM_CH);
      if (w_elig[cand]) begin
        o_idx   = cand;
        o_valid = 1'b1;
      end
    end
    if (o_valid) o_gnt[o_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else if (o_valid) begin
      r_rr <= IDX_W'((int'(o_idx) + 1) % NUM_CH);
    end
  end

endmodule
`default_nettype wire

// File: rtl/gray_ctr_bank_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_ctr_bank_arb : bank of Gray counters sharing one pipelined incrementer  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module gray_ctr_bank_arb
  import gray_ctr_bank_arb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SPEED  = 2,
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       req_i,
  input  logic [NUM_CH-1:0]       clr_i,
  output logic [NUM_CH-1:0]       gnt_o,
  output logic [NUM_CH*WIDTH-1:0] cnt_o,
  output logic                    done_valid_o,
  output logic [IDX_W-1:0]        done_ch_o,
  output logic [WIDTH-1:0]        done_cnt_o,
  output logic                    done_wrap_o
);

  logic [WIDTH-1:0]  r_cnt [NUM_CH];
  logic              r_busy;
  logic [IDX_W-1:0]  r_sel;
  logic [WIDTH-1:0]  r_opnd;

  logic [NUM_CH-1:0] w_mask;
  logic [IDX_W-1:0]  w_idx;
  logic              w_gvalid;
  logic [WIDTH-1:0]  w_inc;
  logic              w_wb;

  // No forwarding: a channel with an op in flight cannot be re-granted.
  always_comb begin
    w_mask = clr_i;
    if (r_busy) w_mask[r_sel] = 1'b1;
  end

  gray_rr_arb #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_req   (req_i),
    .i_mask  (w_mask),
    .o_gnt   (gnt_o),
    .o_idx   (w_idx),
    .o_valid (w_gvalid)
  );

  IncGray #(
    .WIDTH (WIDTH),
    .SPEED (SPEED)
  ) u_inc (
    .i_gray (r_opnd),
    .o_gray (w_inc)
  );

  // A clear of the in-flight channel kills its writeback.
  assign w_wb = r_busy & ~clr_i[r_sel];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= 1'b0;
      r_sel  <= '0;
      r_opnd <= '0;
    end else begin
      r_busy <= w_gvalid;
      r_sel  <= w_idx;
      r_opnd <= r_cnt[w_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr_i[c]) begin
          r_cnt[c] <= '0;
        end else if (w_wb && (r_sel == IDX_W'(c))) begin
          r_cnt[c] <= w_inc;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_valid_o <= 1'b0;
      done_ch_o    <= '0;
      done_cnt_o   <= '0;
      done_wrap_o  <= 1'b0;
    end else begin
      done_valid_o <= w_wb;
      done_ch_o    <= w_wb ? r_sel : '0;
      done_cnt_o   <= w_wb ? w_inc : '0;
      done_wrap_o  <= w_wb & (w_inc == '0);
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt_out
      assign cnt_o[c*WIDTH +: WIDTH] = r_cnt[c];
    end
  endgenerate

  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_gnt_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (gnt_o & ~req_i) == '0);
  a_inc_step : assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_valid_o |-> WIDTH'(gray2bin(word_t'(done_cnt_o))) ==
                     WIDTH'(gray2bin(word_t'($past(r_opnd))) + 1));

endmodule
`default_nettype wire
